// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: forward-select codes and the
// per-stage in-flight record.
package hazard_pkg;

  // Record register-address fields are sized for the largest supported
  // register file; narrower files zero-extend into them.
  localparam int unsigned MAX_RW = 4;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [MAX_RW-1:0] wa;
    logic              load;
    logic              pcw;
  } pipe_ent_t;

  localparam pipe_ent_t BUBBLE = '0;

  // True when a live record writes register r.
  function automatic logic ent_hit(pipe_ent_t e, logic [MAX_RW-1:0] r);
    return e.valid & e.we & (e.wa == r);
  endfunction

endpackage

// File: rtl/pipe_ent_reg.sv
// One pipeline record register: async active-low reset, hold enable and a
// synchronous clear-to-bubble that takes priority over hold.
module pipe_ent_reg
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      hold,
  input  logic      clr,
  input  pipe_ent_t d,
  output pipe_ent_t q
);

  // Record state: bubble on reset or clear, otherwise load unless held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= BUBBLE;
    end else if (clr) begin
      q <= BUBBLE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the F/D/E/M/W pipeline. Tracks the
// E/M/W in-flight records, drives stall/flush/forward-select and counts
// load-use and memory-wait stall cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREGS  = 16,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned PC_REG = 15,
  parameter int unsigned CNT_W  = 32,
  localparam int unsigned RW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [NSRC*RW-1:0]   dec_ra,
  input  logic [NSRC-1:0]      dec_ra_used,
  input  logic                 dec_we,
  input  logic [RW-1:0]        dec_wa,
  input  logic                 dec_load,
  input  logic                 branch_taken_e,
  input  logic                 mem_ready,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 stall_m,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [NSRC*2-1:0]    fwd_sel,
  output logic [CNT_W-1:0]     ldstall_cnt,
  output logic [CNT_W-1:0]     memwait_cnt
);

  localparam logic [MAX_RW-1:0] PC_IDX = MAX_RW'(PC_REG);

  pipe_ent_t dec_ent;
  pipe_ent_t ent_e, ent_m, ent_w;

  logic [NSRC*RW-1:0] ra_e_q;
  logic [NSRC-1:0]    used_e_q;

  logic     ld_src_hit;
  logic     ldstall;
  logic     pcw_pend;
  logic     pcw_w;
  logic     mem_wait;
  fwd_sel_t fwd_arr [NSRC];

  logic [CNT_W-1:0] ldstall_cnt_q, ldstall_cnt_d;
  logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

  assign mem_wait = ~mem_ready;

  // Record describing the instruction currently in D.
  always_comb begin
    dec_ent       = BUBBLE;
    dec_ent.valid = dec_valid;
    dec_ent.we    = dec_we;
    dec_ent.wa    = MAX_RW'(dec_wa);
    dec_ent.load  = dec_load;
    dec_ent.pcw   = dec_we & (MAX_RW'(dec_wa) == PC_IDX);
  end

  // Load-use hazard: a load in E feeds a source that D actually reads.
  always_comb begin
    ld_src_hit = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (dec_valid && dec_ra_used[i] && (MAX_RW'(dec_ra[i*RW +: RW]) == ent_e.wa)) begin
        ld_src_hit = 1'b1;
      end
    end
    ldstall = ent_e.valid & ent_e.load & ent_e.we & ld_src_hit;
  end

  // PC writes still ahead of W block fetch; the one in W only squashes D.
  always_comb begin
    pcw_pend = (dec_valid & dec_we & (MAX_RW'(dec_wa) == PC_IDX))
             | (ent_e.valid & ent_e.pcw)
             | (ent_m.valid & ent_m.pcw);
    pcw_w    = ent_w.valid & ent_w.pcw;
  end

  // Stall/flush outputs; a memory wait freezes everything and suppresses flushes.
  always_comb begin
    stall_f = ldstall | pcw_pend;
    stall_d = ldstall;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = pcw_pend | pcw_w | branch_taken_e;
    flush_e = ldstall | branch_taken_e;
    if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_d = 1'b0;
      flush_e = 1'b0;
    end
  end

  pipe_ent_reg u_ent_e (
    .clk   (clk),
    .reset (reset),
    .hold  (mem_wait),
    .clr   (flush_e),
    .d     (dec_ent),
    .q     (ent_e)
  );

  pipe_ent_reg u_ent_m (
    .clk   (clk),
    .reset (reset),
    .hold  (mem_wait),
    .clr   (1'b0),
    .d     (ent_e),
    .q     (ent_m)
  );

  // W keeps draining during a wait, so it fills with bubbles.
  pipe_ent_reg u_ent_w (
    .clk   (clk),
    .reset (reset),
    .hold  (1'b0),
    .clr   (mem_wait),
    .d     (ent_m),
    .q     (ent_w)
  );

  // E-stage source addresses; a bubble drops its operand-used flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra_e_q   <= '0;
      used_e_q <= '0;
    end else if (mem_ready) begin
      ra_e_q   <= dec_ra;
      used_e_q <= flush_e ? '0 : dec_ra_used;
    end
  end

  // Per-operand forward select; the younger producer in M beats W.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      fwd_arr[i] = FWD_RF;
      if (used_e_q[i] && (MAX_RW'(ra_e_q[i*RW +: RW]) != PC_IDX)) begin
        if (ent_hit(ent_m, MAX_RW'(ra_e_q[i*RW +: RW]))) begin
          fwd_arr[i] = FWD_M;
        end else if (ent_hit(ent_w, MAX_RW'(ra_e_q[i*RW +: RW]))) begin
          fwd_arr[i] = FWD_W;
        end
      end
      fwd_sel[i*2 +: 2] = fwd_arr[i];
    end
  end

  // Saturating performance counter next-state.
  always_comb begin
    ldstall_cnt_d = ldstall_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    if (mem_ready && ldstall && (ldstall_cnt_q != '1)) begin
      ldstall_cnt_d = ldstall_cnt_q + CNT_W'(1);
    end
    if (mem_wait && (memwait_cnt_q != '1)) begin
      memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
    end
  end

  // Performance counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ldstall_cnt_q <= '0;
      memwait_cnt_q <= '0;
    end else begin
      ldstall_cnt_q <= ldstall_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign ldstall_cnt = ldstall_cnt_q;
  assign memwait_cnt = memwait_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed pipeline scenarios plus random stimulus,
// compared each cycle against an instruction-level reference model.
module tb_hazard_scoreboard;

  localparam int NREGS = 16;
  localparam int NSRC  = 2;
  localparam int PC    = 15;
  localparam int RW    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              dec_valid;
  logic [NSRC*RW-1:0] dec_ra;
  logic [NSRC-1:0]   dec_ra_used;
  logic              dec_we;
  logic [RW-1:0]     dec_wa;
  logic              dec_load;
  logic              branch_taken_e;
  logic              mem_ready;

  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic [NSRC*2-1:0] fwd_sel;
  logic [31:0] ldstall_cnt, memwait_cnt;

  logic s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e;
  logic [NSRC*2-1:0] s_fwd_sel;
  logic [3:0] s_ldstall_cnt, s_memwait_cnt;

  hazard_scoreboard #(.NREGS(NREGS), .NSRC(NSRC), .PC_REG(PC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ra(dec_ra),
    .dec_ra_used(dec_ra_used), .dec_we(dec_we), .dec_wa(dec_wa), .dec_load(dec_load),
    .branch_taken_e(branch_taken_e), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .fwd_sel(fwd_sel),
    .ldstall_cnt(ldstall_cnt), .memwait_cnt(memwait_cnt)
  );

  hazard_scoreboard #(.NREGS(NREGS), .NSRC(NSRC), .PC_REG(PC), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ra(dec_ra),
    .dec_ra_used(dec_ra_used), .dec_we(dec_we), .dec_wa(dec_wa), .dec_load(dec_load),
    .branch_taken_e(branch_taken_e), .mem_ready(mem_ready),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .stall_m(s_stall_m),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .fwd_sel(s_fwd_sel),
    .ldstall_cnt(s_ldstall_cnt), .memwait_cnt(s_memwait_cnt)
  );

  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model: one record per in-flight instruction.
  typedef struct {
    bit v;
    bit we;
    bit ld;
    int wa;
  } ins_t;

  ins_t   s_e, s_m, s_w;
  int     s_ra   [NSRC];
  bit     s_used [NSRC];
  longint n_ld, n_mw;

  bit e_stall_f, e_stall_d, e_stall_e, e_stall_m, e_flush_d, e_flush_e, e_ld;
  logic [NSRC*2-1:0] e_fwd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ins_t bub();
    ins_t x;
    x.v = 0; x.we = 0; x.ld = 0; x.wa = 0;
    return x;
  endfunction

  function automatic bit writes(ins_t x, int r);
    return x.v && x.we && (x.wa == r);
  endfunction

  function automatic longint sat(longint n, int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (n > m) ? m : n;
  endfunction

  task automatic model_reset();
    s_e = bub(); s_m = bub(); s_w = bub();
    for (int i = 0; i < NSRC; i++) begin
      s_ra[i] = 0;
      s_used[i] = 0;
    end
    n_ld = 0;
    n_mw = 0;
  endtask

  task automatic eval();
    bit hit, pend, pw;
    int r, code;
    hit = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (dec_valid && dec_ra_used[i] && int'(dec_ra[i*RW +: RW]) == s_e.wa) hit = 1;
    end
    e_ld = s_e.v && s_e.ld && s_e.we && hit;
    pend = (dec_valid && dec_we && int'(dec_wa) == PC) || writes(s_e, PC) || writes(s_m, PC);
    pw   = writes(s_w, PC);
    if (mem_ready) begin
      e_stall_f = e_ld || pend;
      e_stall_d = e_ld;
      e_stall_e = 0;
      e_stall_m = 0;
      e_flush_d = pend || pw || branch_taken_e;
      e_flush_e = e_ld || branch_taken_e;
    end else begin
      e_stall_f = 1; e_stall_d = 1; e_stall_e = 1; e_stall_m = 1;
      e_flush_d = 0; e_flush_e = 0;
    end
    e_fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      r = s_ra[i];
      code = 0;
      if (s_used[i] && r != PC) begin
        if (writes(s_m, r)) code = 2;
        else if (writes(s_w, r)) code = 1;
      end
      e_fwd[2*i +: 2] = 2'(code);
    end
  endtask

  task automatic compare_all();
    eval();
    check("stall_f", stall_f, e_stall_f);
    check("stall_d", stall_d, e_stall_d);
    check("stall_e", stall_e, e_stall_e);
    check("stall_m", stall_m, e_stall_m);
    check("flush_d", flush_d, e_flush_d);
    check("flush_e", flush_e, e_flush_e);
    check("fwd_sel", fwd_sel, e_fwd);
    check("ldstall_cnt", ldstall_cnt, sat(n_ld, 32));
    check("memwait_cnt", memwait_cnt, sat(n_mw, 32));
    check("sat_flags", {s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e, s_fwd_sel},
          {e_stall_f, e_stall_d, e_stall_e, e_stall_m, e_flush_d, e_flush_e, e_fwd});
    check("sat_ldstall_cnt", s_ldstall_cnt, sat(n_ld, 4));
    check("sat_memwait_cnt", s_memwait_cnt, sat(n_mw, 4));
  endtask

  task automatic model_update();
    if (mem_ready) begin
      if (e_ld) n_ld++;
      s_w = s_m;
      s_m = s_e;
      if (e_flush_e) begin
        s_e = bub();
        for (int i = 0; i < NSRC; i++) s_used[i] = 0;
      end else begin
        s_e.v  = dec_valid;
        s_e.we = dec_we;
        s_e.ld = dec_load;
        s_e.wa = int'(dec_wa);
        for (int i = 0; i < NSRC; i++) s_used[i] = dec_ra_used[i];
      end
      for (int i = 0; i < NSRC; i++) s_ra[i] = int'(dec_ra[i*RW +: RW]);
    end else begin
      n_mw++;
      s_w = bub();
    end
  endtask

  task automatic drive(input bit v, input int ra0, input int ra1, input bit [1:0] used,
                       input bit we, input int wa, input bit ld, input bit br, input bit rdy);
    dec_valid      = v;
    dec_ra         = {4'(ra1), 4'(ra0)};
    dec_ra_used    = used;
    dec_we         = we;
    dec_wa         = 4'(wa);
    dec_load       = ld;
    branch_taken_e = br;
    mem_ready      = rdy;
  endtask

  task automatic nop();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic int pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? PC : r;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    nop();
    model_reset();
    #2 reset = 1'b0;
    #10;
    compare_all();
    check("rst_fwd", fwd_sel, 0);
    check("rst_flags", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Load followed by a dependent use.
    drive(1, 0, 0, 2'b00, 1, 3, 1, 0, 1); cyc();
    drive(1, 3, 0, 2'b01, 1, 4, 0, 0, 1); sample();
    check("lu_stall_f", stall_f, 1);
    check("lu_stall_d", stall_d, 1);
    check("lu_flush_e", flush_e, 1);
    advance();
    cyc();
    nop(); sample();
    check("lu_fwd0", fwd_sel[1:0], 2'b01);
    check("lu_cnt", ldstall_cnt, 1);
    advance();
    repeat (3) cyc();

    // ALU chain: M then W forwarding, no stalls.
    drive(1, 0, 0, 2'b00, 1, 1, 0, 0, 1); cyc();
    drive(1, 0, 1, 2'b10, 1, 2, 0, 0, 1); cyc();
    drive(1, 1, 0, 2'b01, 1, 5, 0, 0, 1); sample();
    check("chain_fwd1", fwd_sel[3:2], 2'b10);
    check("chain_nostall", {stall_f, stall_d}, 0);
    advance();
    nop(); sample();
    check("chain_fwd0", fwd_sel[1:0], 2'b01);
    advance();
    repeat (3) cyc();

    // Write to the PC travelling D, E, M, W.
    drive(1, 0, 0, 2'b00, 1, PC, 0, 0, 1); sample();
    check("pcw_d", {stall_f, flush_d}, 2'b11);
    advance();
    nop();
    for (int k = 0; k < 2; k++) begin
      sample();
      check("pcw_em", {stall_f, flush_d}, 2'b11);
      advance();
    end
    sample();
    check("pcw_w", {stall_f, flush_d}, 2'b01);
    advance();
    repeat (2) cyc();

    // Memory wait with a store in M and an ALU op held in E.
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 1); cyc();
    drive(1, 0, 0, 2'b00, 1, 6, 0, 0, 1); cyc();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    repeat (4) begin
      sample();
      check("mw_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'hf);
      check("mw_flush", {flush_d, flush_e}, 0);
      advance();
    end
    drive(1, 6, 0, 2'b01, 1, 7, 0, 0, 1); sample();
    check("mw_cnt", memwait_cnt, 4);
    advance();
    nop(); sample();
    check("mw_e_kept", fwd_sel[1:0], 2'b10);
    advance();

    // Branch taken while memory waits, then resumes.
    drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 0); sample();
    check("br_wait", {flush_d, flush_e}, 0);
    advance();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 1); sample();
    check("br_ready", {flush_d, flush_e}, 2'b11);
    advance();
    nop();
    repeat (2) cyc();

    // Repeated LDR R3,[R3]: load-use stall every other cycle.
    do_reset();
    drive(1, 3, 0, 2'b01, 1, 3, 1, 0, 1);
    repeat (40) cyc();
    nop(); sample();
    check("sat_ld15", s_ldstall_cnt, 15);
    check("ld20", ldstall_cnt, 20);
    advance();

    // Random traffic against the model.
    repeat (800) begin
      drive($urandom_range(0, 9) < 8, pick_reg(), pick_reg(), 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 7, pick_reg(), $urandom_range(0, 9) < 3,
            $urandom_range(0, 15) == 0, $urandom_range(0, 9) != 0);
      cyc();
    end

    // Reset asserted in the middle of a memory wait.
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_mid_cnt", {ldstall_cnt, memwait_cnt}, 0);
    compare_all();
    mem_ready = 1'b1;
    #1;
    check("rst_mid_out", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, fwd_sel}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
